ahb_apb_bridge: RTL and testbench

AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

---
 rtl/ahb_apb_bridge.sv | 139 +++++++++++++
 tb/tb_ahb_apb_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge: one outstanding word transfer, three-slave one-hot decode
// at 0x4000_xxxx..0x4002_xxxx, with a two-cycle ERROR response for unmapped or failed accesses.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic [1:0]            HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state;
    logic [NUM_SLAVES-1:0] sel_dec;
    logic                  mapped;
    logic                  xfer_req;
    logic                  unused_inputs;

    // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY never start an APB access.
    assign xfer_req      = HTRANS[1];
    assign unused_inputs = ^{HSIZE, HTRANS[0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (HADDR[31:16] == 16'(32'h4000 + i)) sel_dec[i] = 1'b1;
        end
    end

    assign mapped = |sel_dec;

    // HREADY/HRESP/HRDATA track PREADY/PSLVERR in the same cycle, so they stay combinational.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        HRDATA = '0;
        case (state)
            ST_SETUP: HREADY = 1'b0;
            ST_ENABLE: begin
                if (!PREADY) begin
                    HREADY = 1'b0;
                end else if (PSLVERR) begin
                    HREADY = 1'b0;
                    HRESP  = RESP_ERROR;
                end else if (!PWRITE) begin
                    HRDATA = PRDATA;
                end
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = RESP_ERROR;
            end
            ST_ERR2: HRESP = RESP_ERROR;
            default: ;
        endcase
    end

    // HWDATA is held by the master while HREADY is low, so it can pass straight through.
    assign PWDATA = ((state == ST_SETUP || state == ST_ENABLE) && PWRITE) ? HWDATA : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state   <= ST_IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer_req) begin
                        PADDR  <= HADDR;
                        PWRITE <= HWRITE;
                        PSEL   <= sel_dec;
                        state  <= mapped ? ST_SETUP : ST_ERR1;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    if (PREADY) begin
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            PSEL  <= '0;
                            state <= ST_ERR2;
                        end else if (xfer_req) begin
                            PADDR  <= HADDR;
                            PWRITE <= HWRITE;
                            PSEL   <= sel_dec;
                            state  <= mapped ? ST_SETUP : ST_ERR1;
                        end else begin
                            PSEL  <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                // HREADY is high here but a presented transfer is deliberately dropped.
                ST_ERR2: state <= ST_IDLE;
                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: three APB memory slaves with programmable wait
// states and one error address; AHB master driven by tasks, outputs sampled on negedge.
module tb_ahb_apb_bridge;

    localparam int NS = 3;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] PADDR;
    logic [NS-1:0] PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    // APB slave model: word memories, wait-state counter, one address that answers PSLVERR.
    logic [31:0] mem [NS][1024];
    int          wait_cycles = 0;
    int          en_cnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    always_comb begin
        PRDATA = '0;
        for (int i = 0; i < NS; i++) if (PSEL[i]) PRDATA = mem[i][PADDR[11:2]];
        PREADY  = (en_cnt >= wait_cycles);
        PSLVERR = PENABLE && PREADY && (PADDR == err_addr);
    end

    always @(posedge HCLK) begin
        if (!PENABLE) en_cnt <= 0;
        else if (!PREADY) en_cnt <= en_cnt + 1;
        if (PENABLE && PREADY && PWRITE && !PSLVERR)
            for (int i = 0; i < NS; i++) if (PSEL[i]) mem[i][PADDR[11:2]] <= PWDATA;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  nwait;
        logic [7:0]  en_cycles;
        logic        done;
        logic [1:0]  resp;
        logic [1:0]  prev_resp;
        logic [31:0] rdata;
        logic [2:0]  psel0;
        logic [2:0]  psel_or;
        logic [31:0] paddr0;
        logic [31:0] pwdata0;
        logic        pwrite0;
        logic        penable0;
    } xfer_res_t;

    // One single AHB transfer; records the first data-phase cycle and the completion cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        output xfer_res_t r);
        r = '0;
        @(negedge HCLK);
        HADDR = addr; HWRITE = wr; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HWDATA = wdata;
        for (int c = 0; c < 20; c++) begin
            @(negedge HCLK);
            if (c == 0) begin
                r.psel0 = PSEL; r.paddr0 = PADDR; r.pwrite0 = PWRITE;
                r.pwdata0 = PWDATA; r.penable0 = PENABLE;
            end
            r.psel_or = r.psel_or | PSEL;
            if (PENABLE) r.en_cycles++;
            r.prev_resp = r.resp;
            r.resp = HRESP;
            if (HREADY) begin
                r.rdata = HRDATA;
                r.done = 1'b1;
                break;
            end
            r.nwait++;
        end
        check("xfer_done", {31'b0, r.done}, 32'd1);
        @(posedge HCLK); #1;
        HWDATA = '0;
    endtask

    xfer_res_t r;

    initial begin
        for (int s = 0; s < NS; s++) for (int w = 0; w < 1024; w++) mem[s][w] = '0;
        mem[0][2] = 32'hCAFE_BABE;
        HRESETn = 1'b0; HADDR = 32'h4000_0000; HTRANS = 2'b10; HWRITE = 1'b1;
        HSIZE = 3'b010; HWDATA = 32'h1234_5678;
        #1;
        check("rst_hready", {31'b0, HREADY}, 32'd1);
        check("rst_hresp", {30'b0, HRESP}, 32'd0);
        check("rst_psel", {29'b0, PSEL}, 32'd0);
        check("rst_penable", {31'b0, PENABLE}, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        repeat (2) @(negedge HCLK);
        HTRANS = 2'b00; HWDATA = '0; HWRITE = 1'b0;
        HRESETn = 1'b1;

        // BUSY is ignored with zero-wait OKAY
        @(negedge HCLK); HTRANS = 2'b01; HADDR = 32'h4000_0000;
        @(posedge HCLK); #1; HTRANS = 2'b00;
        @(negedge HCLK);
        check("busy_hready", {31'b0, HREADY}, 32'd1);
        check("busy_psel", {29'b0, PSEL}, 32'd0);
        check("busy_hresp", {30'b0, HRESP}, 32'd0);

        // basic write, slave 0 word 1
        xfer(32'h4000_0004, 1'b1, 32'hDEAD_BEEF, r);
        check("wr_psel", {29'b0, r.psel0}, 32'd1);
        check("wr_paddr", r.paddr0, 32'h4000_0004);
        check("wr_pwrite", {31'b0, r.pwrite0}, 32'd1);
        check("wr_pwdata", r.pwdata0, 32'hDEAD_BEEF);
        check("wr_setup_penable", {31'b0, r.penable0}, 32'd0);
        check("wr_nwait", {24'b0, r.nwait}, 32'd1);
        check("wr_en_cycles", {24'b0, r.en_cycles}, 32'd1);
        check("wr_resp", {30'b0, r.resp}, 32'd0);
        check("wr_hrdata_zero", r.rdata, 32'd0);
        check("wr_mem", mem[0][1], 32'hDEAD_BEEF);

        // read, slave 0 word 2
        xfer(32'h4000_0008, 1'b0, 32'h0, r);
        check("rd_data", r.rdata, 32'hCAFE_BABE);
        check("rd_pwrite", {31'b0, r.pwrite0}, 32'd0);
        check("rd_pwdata_zero", r.pwdata0, 32'd0);
        check("rd_nwait", {24'b0, r.nwait}, 32'd1);
        check("rd_resp", {30'b0, r.resp}, 32'd0);
        @(negedge HCLK);
        check("rd_hrdata_after", HRDATA, 32'd0);

        // slave select
        xfer(32'h4001_0000, 1'b1, 32'h1234_5678, r);
        check("s1_psel", {29'b0, r.psel0}, 32'd2);
        check("s1_mem", mem[1][0], 32'h1234_5678);
        xfer(32'h4002_0000, 1'b1, 32'h8765_4321, r);
        check("s2_psel", {29'b0, r.psel0}, 32'd4);
        check("s2_mem", mem[2][0], 32'h8765_4321);

        // back-to-back writes: second SETUP directly follows first ENABLE
        @(negedge HCLK);
        HADDR = 32'h4000_0010; HWRITE = 1'b1; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HWDATA = 32'hAAAA_5555; HADDR = 32'h4000_0014; HWRITE = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        check("b2b_setup1_paddr", PADDR, 32'h4000_0010);
        check("b2b_setup1_hready", {31'b0, HREADY}, 32'd0);
        @(negedge HCLK);
        check("b2b_enable1_hready", {31'b0, HREADY}, 32'd1);
        check("b2b_enable1_penable", {31'b0, PENABLE}, 32'd1);
        @(posedge HCLK); #1;
        HWDATA = 32'h5555_AAAA; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        @(negedge HCLK);
        check("b2b_setup2_penable", {31'b0, PENABLE}, 32'd0);
        check("b2b_setup2_psel", {29'b0, PSEL}, 32'd1);
        check("b2b_setup2_paddr", PADDR, 32'h4000_0014);
        check("b2b_setup2_pwdata", PWDATA, 32'h5555_AAAA);
        @(negedge HCLK);
        check("b2b_enable2_hready", {31'b0, HREADY}, 32'd1);
        @(posedge HCLK); #1; HWDATA = '0;
        check("b2b_mem0", mem[0][4], 32'hAAAA_5555);
        check("b2b_mem1", mem[0][5], 32'h5555_AAAA);

        // slave error: ENABLE(HREADY=0,ERROR) then ERR2(HREADY=1,ERROR)
        err_addr = 32'h4000_0500;
        xfer(32'h4000_0500, 1'b1, 32'h0F0F_0F0F, r);
        check("slverr_nwait", {24'b0, r.nwait}, 32'd2);
        check("slverr_resp", {30'b0, r.resp}, 32'd1);
        check("slverr_prev_resp", {30'b0, r.prev_resp}, 32'd1);
        check("slverr_no_store", mem[0][10'h140], 32'd0);
        @(negedge HCLK);
        check("slverr_idle_hresp", {30'b0, HRESP}, 32'd0);
        check("slverr_idle_hready", {31'b0, HREADY}, 32'd1);
        err_addr = 32'hFFFF_FFFF;

        // unmapped address
        xfer(32'h5000_0000, 1'b1, 32'h1111_1111, r);
        check("unmap_nwait", {24'b0, r.nwait}, 32'd1);
        check("unmap_resp", {30'b0, r.resp}, 32'd1);
        check("unmap_prev_resp", {30'b0, r.prev_resp}, 32'd1);
        check("unmap_psel", {29'b0, r.psel_or}, 32'd0);
        check("unmap_penable", {24'b0, r.en_cycles}, 32'd0);

        // transfer presented during ERR2 is dropped
        @(negedge HCLK);
        HADDR = 32'h4300_0000; HWRITE = 1'b1; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        @(posedge HCLK); #1;
        HADDR = 32'h4000_0018; HWRITE = 1'b1; HTRANS = 2'b10; HWDATA = 32'h7777_7777;
        @(negedge HCLK);
        check("err2_hready", {31'b0, HREADY}, 32'd1);
        check("err2_hresp", {30'b0, HRESP}, 32'd1);
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        @(negedge HCLK);
        check("err2_drop_psel", {29'b0, PSEL}, 32'd0);
        check("err2_drop_hready", {31'b0, HREADY}, 32'd1);
        @(posedge HCLK); #1; HWDATA = '0;
        check("err2_drop_mem", mem[0][6], 32'd0);

        // two PREADY=0 cycles stretch ENABLE to three cycles
        wait_cycles = 2;
        xfer(32'h4001_0004, 1'b1, 32'h0BAD_F00D, r);
        check("wait_nwait", {24'b0, r.nwait}, 32'd3);
        check("wait_en_cycles", {24'b0, r.en_cycles}, 32'd3);
        check("wait_resp", {30'b0, r.resp}, 32'd0);
        check("wait_mem", mem[1][1], 32'h0BAD_F00D);
        wait_cycles = 0;

        // reset during SETUP aborts the write; next transfer is taken on the first edge after release
        @(negedge HCLK);
        HADDR = 32'h4001_0008; HWRITE = 1'b1; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HADDR = '0; HWDATA = 32'h1111_2222;
        @(negedge HCLK);
        check("abort_setup_psel", {29'b0, PSEL}, 32'd2);
        #1 HRESETn = 1'b0;
        #1;
        check("abort_psel", {29'b0, PSEL}, 32'd0);
        check("abort_paddr", PADDR, 32'd0);
        check("abort_pwdata", PWDATA, 32'd0);
        check("abort_hready", {31'b0, HREADY}, 32'd1);
        @(negedge HCLK);
        HWDATA = '0; HWRITE = 1'b0; HADDR = 32'h4001_0000; HTRANS = 2'b10;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HADDR = '0;
        @(negedge HCLK);
        check("resume_psel", {29'b0, PSEL}, 32'd2);
        check("abort_no_store", mem[1][2], 32'd0);
        @(negedge HCLK);
        check("resume_hready", {31'b0, HREADY}, 32'd1);
        check("resume_rdata", HRDATA, 32'h1234_5678);
        @(negedge HCLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
